// File: rtl/attn_pkg.sv
// Shared definitions for the attention-array feeder: default sizes and the
// loader state encoding.
package attn_pkg;

   localparam int DATA_W_DEF      = 16;
   localparam int WORDS_DEF       = 32;
   localparam int TIMEOUT_CYC_DEF = 255;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD_K = 3'd1;
   localparam logic [2:0] S_LOAD_Q = 3'd2;
   localparam logic [2:0] S_LOAD_V = 3'd3;
   localparam logic [2:0] S_RUN    = 3'd4;
   localparam logic [2:0] S_FINISH = 3'd5;

   function automatic logic is_load_state(input logic [2:0] s);
      return (s == S_LOAD_K) || (s == S_LOAD_Q) || (s == S_LOAD_V);
   endfunction

endpackage

// File: rtl/qkv_word_buffer.sv
// WORDS x DATA_W register bank with one indexed write port; the whole bank is
// presented flat so the PE array sees every element at once.
module qkv_word_buffer
   import attn_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int WORDS  = WORDS_DEF,
   localparam int IDX_W = $clog2(WORDS)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_we,
   input  logic [IDX_W-1:0]          i_idx,
   input  logic [DATA_W-1:0]         i_data,
   output logic [DATA_W*WORDS-1:0]   o_buf
);

   genvar gi;
   generate
      for (gi = 0; gi < WORDS; gi++) begin : g_word
         logic [DATA_W-1:0] r_word;
         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               r_word <= '0;
            else if (i_we && (i_idx == IDX_W'(gi)))
               r_word <= i_data;
         end
         assign o_buf[gi*DATA_W +: DATA_W] = r_word;
      end
   endgenerate

endmodule

// File: rtl/qkv_stream_loader.sv
// Stream-to-operand loader for the 8x8 PE attention array: fills key, query,
// value buffers then runs the array. Optional RUN timeout: QKV_LOADER_TIMEOUT_EN.
module qkv_stream_loader
   import attn_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int WORDS       = WORDS_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    in_valid,
   input  logic [DATA_W-1:0]       in_data,
   output logic                    in_ready,
   output logic [DATA_W*WORDS-1:0] key,
   output logic [DATA_W*WORDS-1:0] query,
   output logic [DATA_W*WORDS-1:0] value,
   output logic                    pe_en,
   input  logic                    pe_all_done,
   output logic                    busy,
   output logic                    done,
   output logic                    err
);

   localparam int IDX_W = $clog2(WORDS);

   logic [2:0]       r_state;
   logic [2:0]       w_state_next;
   logic [IDX_W-1:0] r_word_cnt;
   logic             r_in_ready;
   logic             r_pe_en;
   logic             r_busy;
   logic             r_done;
   logic             r_err;
   logic             w_accept;
   logic             w_last_word;
   logic             w_timeout;

   assign w_accept    = in_valid & r_in_ready;
   assign w_last_word = (r_word_cnt == IDX_W'(WORDS - 1));

`ifdef QKV_LOADER_TIMEOUT_EN
   localparam int TCNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [TCNT_W-1:0] r_run_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_run_cnt <= '0;
      else if (r_state != S_RUN)
         r_run_cnt <= '0;
      else
         r_run_cnt <= r_run_cnt + 1'b1;
   end

   // Expiry on the TIMEOUT_CYC-th RUN cycle; a completion seen that same cycle takes priority.
   assign w_timeout = (r_state == S_RUN) && !pe_all_done &&
                      (r_run_cnt == TCNT_W'(TIMEOUT_CYC - 1));
`else
   logic w_unused_timeout_cfg;
   assign w_unused_timeout_cfg = (TIMEOUT_CYC > 0);
   assign w_timeout = 1'b0;
`endif

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:   if (start) w_state_next = S_LOAD_K;
         S_LOAD_K: if (w_accept && w_last_word) w_state_next = S_LOAD_Q;
         S_LOAD_Q: if (w_accept && w_last_word) w_state_next = S_LOAD_V;
         S_LOAD_V: if (w_accept && w_last_word) w_state_next = S_RUN;
         S_RUN:    if (pe_all_done || w_timeout) w_state_next = S_FINISH;
         S_FINISH: w_state_next = S_IDLE;
         default:  w_state_next = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they change together with it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_word_cnt <= '0;
         r_in_ready <= 1'b0;
         r_pe_en    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_in_ready <= is_load_state(w_state_next);
         r_pe_en    <= (w_state_next == S_RUN);
         r_busy     <= (w_state_next != S_IDLE);
         r_done     <= (w_state_next == S_FINISH);
         if (w_accept)
            r_word_cnt <= w_last_word ? '0 : r_word_cnt + 1'b1;
         if ((r_state == S_IDLE) && start)
            r_err <= 1'b0;
         else if (w_timeout)
            r_err <= 1'b1;
      end
   end

   qkv_word_buffer #(.DATA_W(DATA_W), .WORDS(WORDS)) u_key_buf (
      .clk   (clk),
      .rst   (rst),
      .i_we  (w_accept && (r_state == S_LOAD_K)),
      .i_idx (r_word_cnt),
      .i_data(in_data),
      .o_buf (key)
   );

   qkv_word_buffer #(.DATA_W(DATA_W), .WORDS(WORDS)) u_query_buf (
      .clk   (clk),
      .rst   (rst),
      .i_we  (w_accept && (r_state == S_LOAD_Q)),
      .i_idx (r_word_cnt),
      .i_data(in_data),
      .o_buf (query)
   );

   qkv_word_buffer #(.DATA_W(DATA_W), .WORDS(WORDS)) u_value_buf (
      .clk   (clk),
      .rst   (rst),
      .i_we  (w_accept && (r_state == S_LOAD_V)),
      .i_idx (r_word_cnt),
      .i_data(in_data),
      .o_buf (value)
   );

   assign in_ready = r_in_ready;
   assign pe_en    = r_pe_en;
   assign busy     = r_busy;
   assign done     = r_done;
   assign err      = r_err;

endmodule
